// File: rtl/regfile_pkg.sv
// Shared defaults and type aliases for the scoreboarded register file.
package regfile_pkg;

   localparam int DEF_DATA_W   = 19;
   localparam int DEF_NUM_REGS = 8;
   localparam int DEF_ADDR_W   = $clog2(DEF_NUM_REGS);

   typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
   typedef logic [DEF_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_rd_port.sv
// One read port: selects the addressed register, forwards a same-cycle write
// and reports whether the register still waits on an outstanding producer.
module regfile_rd_port
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int ADDR_W   = $clog2(NUM_REGS),
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic [ADDR_W-1:0]                rd_addr_i,
   input  logic [NUM_REGS-1:0][DATA_W-1:0]  regs_i,
   input  logic [NUM_REGS-1:0]              pending_i,
   input  logic                             wr_en_i,
   input  logic [ADDR_W-1:0]                wr_addr_i,
   input  logic [DATA_W-1:0]                wr_data_i,
   output logic [DATA_W-1:0]                rd_data_o,
   output logic                             rd_busy_o
);

   logic w_wr_hit;

   // A write to the hardwired zero register is never forwarded.
   always_comb begin
      w_wr_hit = 1'b0;
      if ((BYPASS != 0) && wr_en_i && (wr_addr_i == rd_addr_i) &&
          !((ZERO_REG != 0) && (wr_addr_i == {ADDR_W{1'b0}}))) begin
         w_wr_hit = 1'b1;
      end else begin
         w_wr_hit = 1'b0;
      end
   end

   // Output select: forwarded write data clears the busy indication.
   always_comb begin
      rd_data_o = {DATA_W{1'b0}};
      rd_busy_o = 1'b0;
      if (w_wr_hit) begin
         rd_data_o = wr_data_i;
         rd_busy_o = 1'b0;
      end else begin
         rd_data_o = regs_i[rd_addr_i];
         rd_busy_o = pending_i[rd_addr_i];
      end
   end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with a pending-writeback scoreboard; storage and
// scoreboard flops live here, per-port read logic in regfile_rd_port.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1,
   localparam int ADDR_W  = $clog2(NUM_REGS)
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_RD-1:0][ADDR_W-1:0]    rs_addr_i,
   output logic [NUM_RD-1:0][DATA_W-1:0]    rs_data_o,
   output logic [NUM_RD-1:0]                rs_busy_o,
   input  logic                             wr_en_i,
   input  logic [ADDR_W-1:0]                wr_addr_i,
   input  logic [DATA_W-1:0]                wr_data_i,
   input  logic                             issue_en_i,
   input  logic [ADDR_W-1:0]                issue_addr_i,
   output logic [NUM_REGS-1:0]              pending_o,
   output logic                             hazard_o
);

   logic [NUM_REGS-1:0][DATA_W-1:0] r_regs;
   logic [NUM_REGS-1:0]             r_pending;
   logic [NUM_REGS-1:0]             w_pending_nxt;
   logic                            w_wr_allowed;

   // Writes to the hardwired zero register are dropped entirely.
   always_comb begin
      w_wr_allowed = 1'b0;
      if (wr_en_i && !((ZERO_REG != 0) && (wr_addr_i == {ADDR_W{1'b0}}))) begin
         w_wr_allowed = 1'b1;
      end else begin
         w_wr_allowed = 1'b0;
      end
   end

   // Scoreboard next state: clear on writeback, then set on issue so a new
   // producer to the same register wins.
   always_comb begin
      w_pending_nxt = r_pending;
      if (wr_en_i) begin
         w_pending_nxt[wr_addr_i] = 1'b0;
      end else begin
         w_pending_nxt = r_pending;
      end
      if (issue_en_i) begin
         w_pending_nxt[issue_addr_i] = 1'b1;
      end else begin
         w_pending_nxt[issue_addr_i] = w_pending_nxt[issue_addr_i];
      end
      if (ZERO_REG != 0) begin
         w_pending_nxt[0] = 1'b0;
      end else begin
         w_pending_nxt[0] = w_pending_nxt[0];
      end
   end

   // Register storage.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_regs <= {(NUM_REGS*DATA_W){1'b0}};
      end else if (w_wr_allowed) begin
         r_regs[wr_addr_i] <= wr_data_i;
      end
   end

   // Scoreboard flops; reset discards every outstanding producer.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pending <= {NUM_REGS{1'b0}};
      end else begin
         r_pending <= w_pending_nxt;
      end
   end

   assign pending_o = r_pending;
   assign hazard_o  = |rs_busy_o;

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      regfile_rd_port #(
         .DATA_W   (DATA_W),
         .NUM_REGS (NUM_REGS),
         .ADDR_W   (ADDR_W),
         .ZERO_REG (ZERO_REG),
         .BYPASS   (BYPASS)
      ) u_rd_port (
         .rd_addr_i (rs_addr_i[k]),
         .regs_i    (r_regs),
         .pending_i (r_pending),
         .wr_en_i   (wr_en_i),
         .wr_addr_i (wr_addr_i),
         .wr_data_i (wr_data_i),
         .rd_data_o (rs_data_o[k]),
         .rd_busy_o (rs_busy_o[k])
      );
   end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 19, register data width in bits.
REQ-002 SHALL have parameter NUM_REGS, default 8, number of architectural registers (power of two, >=2).
REQ-003 SHALL have parameter NUM_RD, default 2, number of independent read ports (1..4).
REQ-004 SHALL have parameter ZERO_REG, default 1: 1 hardwires register 0 to zero, 0 makes it a normal register.
REQ-005 SHALL have parameter BYPASS, default 1: 1 forwards same-cycle write data to readers, 0 returns stored value.
REQ-006 SHALL derive localparam ADDR_W = clog2(NUM_REGS).
REQ-007 SHALL have one clock; reset is synchronous and active-high.
REQ-008 clk  input  1  rising-edge clock.
REQ-009 reset  input  1  synchronous, active-high reset.
REQ-010 rs_addr_i  input  NUM_RD x ADDR_W  read address per port.
REQ-011 rs_data_o  output  NUM_RD x DATA_W  read data per port, combinational.
REQ-012 rs_busy_o  output  NUM_RD  per port: addressed register awaits an outstanding writeback.
REQ-013 wr_en_i  input  1  writeback strobe.
REQ-014 wr_addr_i  input  ADDR_W  writeback destination.
REQ-015 wr_data_i  input  DATA_W  writeback data.
REQ-016 issue_en_i  input  1  marks issue_addr_i pending (new producer issued).
REQ-017 issue_addr_i  input  ADDR_W  destination of the issued instruction.
REQ-018 pending_o  output  NUM_REGS  registered scoreboard vector, bit i = register i pending.
REQ-019 hazard_o  output  1  OR of rs_busy_o over all ports.

Function
REQ-020 Write: on clk edge with wr_en_i=1 and reset=0, regs[wr_addr_i] SHALL take wr_data_i; no other register changes.
REQ-021 With ZERO_REG=1: writes to address 0 SHALL be discarded, reads of 0 SHALL return 0, pending_o[0] SHALL stay 0, issue to 0 ignored.
REQ-022 Read: rs_data_o[k] SHALL equal regs[rs_addr_i[k]] with zero cycles latency.
REQ-023 BYPASS=1: if wr_en_i=1 and wr_addr_i==rs_addr_i[k] (and not zero-reg case), rs_data_o[k] SHALL equal wr_data_i in the same cycle.
REQ-024 Scoreboard: issue_en_i=1 SHALL set pending[issue_addr_i] at next edge.
REQ-025 wr_en_i=1 SHALL clear pending[wr_addr_i] at next edge.
REQ-026 Simultaneous issue and write to same address: pending SHALL end set (issue wins, new producer).
REQ-027 Simultaneous issue and write to different addresses: both updates SHALL apply.
REQ-028 rs_busy_o[k] SHALL be pending[rs_addr_i[k]], masked to 0 when BYPASS=1 and a same-cycle write hits that address.
REQ-029 Multiple read ports addressing the same register SHALL return identical data and busy.
REQ-030 Write with pending bit already clear SHALL update data and leave pending clear (no error).

Reset
REQ-031 While reset=1 at an edge, all registers SHALL become 0 and pending_o SHALL become all-zero; wr_en_i and issue_en_i SHALL be ignored that cycle.
REQ-032 After reset: rs_data_o all 0 (absent bypass), rs_busy_o 0, hazard_o 0.
REQ-033 Reset asserted mid-operation SHALL discard all outstanding pending bits without any writeback.

Structure
REQ-034 Package regfile_pkg SHALL hold default DATA_W/NUM_REGS constants and typedefs reg_addr_t, reg_data_t.
REQ-035 One sub-module regfile_rd_port (address mux + bypass compare + busy mask) SHALL be instantiated NUM_RD times via generate.
REQ-036 Storage and scoreboard flops SHALL live in regfile_sb; no latches.

Verification (DATA_W=19, NUM_REGS=8, NUM_RD=2, defaults)
REQ-037 Reset, then write r3=0x5A5A5, read port0 r3 next cycle -> 0x5A5A5; port1 r0 -> 0.
REQ-038 Write r0=0x7FFFF, then read r0 -> 0; pending_o[0] stays 0 after issue to r0.
REQ-039 Same cycle wr r5=0x12345 and port1 reads r5 -> rs_data_o[1]=0x12345, rs_busy_o[1]=0.
REQ-040 Issue r2, next cycle read r2 -> busy=1, hazard_o=1; writeback r2=0x00011 -> following cycle busy=0, data 0x00011.
REQ-041 Same cycle issue r4 and write r4=0x00F00 -> pending_o[4]=1, stored r4=0x00F00.
REQ-042 Issue r1, r6, assert reset one cycle -> pending_o=0, r1/r6 read 0, hazard_o=0.
